round_judge: RTL

- Producer side of the win/round-end interface: runs one reaction-time round per start request and reports the outcome as `o_is_win` plus a one-cycle `o_round_ended` strobe.
- These outputs drive the rating counter's `i_is_win` / `i_round_ended` inputs directly.
- Sits between the player controls (start, button) and the rating/score logic.
- Also exports the GO indicator and the measured reaction time for display.

---
 rtl/round_judge.sv | 115 +++++++++++
 1 files changed

// File: rtl/round_judge.sv
// Reaction-time round judge: runs one ARM/GO round per start and reports win/foul/timeout
// with a one-cycle round_ended strobe; all outputs registered, no backpressure (results held until next strobe).
module round_judge #(
  parameter int          MIN_DELAY     = 64,
  parameter int          RAND_BITS     = 8,
  parameter int          WINDOW_CYCLES = 1000,
  parameter int          REACT_WIDTH   = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_button,
  output logic                   o_go,
  output logic                   o_busy,
  output logic                   o_round_ended,
  output logic                   o_is_win,
  output logic                   o_foul,
  output logic [REACT_WIDTH-1:0] o_reaction_time
);

  localparam int DLY_W = $clog2(MIN_DELAY + (1 << RAND_BITS));

  typedef enum logic [1:0] {IDLE, ARM, GO, DONE} state_t;

  state_t                 state, state_nxt;
  logic [15:0]            lfsr;
  logic                   btn_prev;
  logic                   rise;
  logic [DLY_W-1:0]       dly_cnt, dly_cnt_nxt;
  logic [REACT_WIDTH-1:0] go_cnt, go_cnt_nxt;
  logic                   res_vld, res_win, res_foul;
  logic [REACT_WIDTH-1:0] res_time;

  assign rise = i_button & ~btn_prev;

  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    go_cnt_nxt  = go_cnt;
    res_vld     = 1'b0;
    res_win     = 1'b0;
    res_foul    = 1'b0;
    res_time    = '0;
    case (state)
      IDLE: begin
        if (i_start) begin
          dly_cnt_nxt = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_BITS-1:0]);
          state_nxt   = ARM;
        end
      end
      ARM: begin
        // dly_cnt holds the ARM cycles remaining including this one
        if (rise) begin
          state_nxt = DONE;
          res_vld   = 1'b1;
          res_foul  = 1'b1;
        end else if (dly_cnt == DLY_W'(1)) begin
          state_nxt  = GO;
          go_cnt_nxt = '0;
        end else begin
          dly_cnt_nxt = dly_cnt - DLY_W'(1);
        end
      end
      GO: begin
        // a press on the last window cycle beats the timeout
        if (rise) begin
          state_nxt = DONE;
          res_vld   = 1'b1;
          res_win   = 1'b1;
          res_time  = go_cnt;
        end else if (go_cnt == REACT_WIDTH'(WINDOW_CYCLES - 1)) begin
          state_nxt = DONE;
          res_vld   = 1'b1;
          res_time  = REACT_WIDTH'(WINDOW_CYCLES);
        end else begin
          go_cnt_nxt = go_cnt + REACT_WIDTH'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      lfsr            <= LFSR_SEED;
      btn_prev        <= 1'b0;
      dly_cnt         <= '0;
      go_cnt          <= '0;
      o_go            <= 1'b0;
      o_busy          <= 1'b0;
      o_round_ended   <= 1'b0;
      o_is_win        <= 1'b0;
      o_foul          <= 1'b0;
      o_reaction_time <= '0;
    end else begin
      state         <= state_nxt;
      lfsr          <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      btn_prev      <= i_button;
      dly_cnt       <= dly_cnt_nxt;
      go_cnt        <= go_cnt_nxt;
      o_go          <= (state_nxt == GO);
      o_busy        <= (state_nxt != IDLE);
      o_round_ended <= res_vld;
      if (res_vld) begin
        o_is_win        <= res_win;
        o_foul          <= res_foul;
        o_reaction_time <= res_time;
      end
    end
  end

endmodule
